// File: rtl/donut_ray_issuer.sv
// Initiator for the donut hit-test engine: walks a COLS x ROWS grid, issues one march per sample and
// returns a shaded result per grid point. Define DONUT_ORDERED_DITHER_EN to add 2x2 Bayer dither to the shade.
module donut_ray_issuer #(
    parameter int COLS  = 40,
    parameter int ROWS  = 30,
    parameter int ITERS = 8,
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] org_x,
    input  logic [15:0] org_y,
    input  logic [15:0] org_z,
    input  logic [15:0] ray0_x,
    input  logic [15:0] ray0_y,
    input  logic [15:0] ray0_z,
    input  logic [15:0] cstep_x,
    input  logic [15:0] cstep_y,
    input  logic [15:0] cstep_z,
    input  logic [15:0] rstep_x,
    input  logic [15:0] rstep_y,
    input  logic [15:0] rstep_z,
    input  logic [15:0] lin_x,
    input  logic [15:0] lin_y,
    input  logic [15:0] lin_z,
    output logic        eng_start,
    output logic [15:0] eng_px,
    output logic [15:0] eng_py,
    output logic [15:0] eng_pz,
    output logic [15:0] eng_rx,
    output logic [15:0] eng_ry,
    output logic [15:0] eng_rz,
    output logic [15:0] eng_lx,
    output logic [15:0] eng_ly,
    output logic [15:0] eng_lz,
    input  logic        eng_hit,
    input  logic [15:0] eng_light,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_col,
    output logic [4:0]  out_row,
    output logic        out_hit,
    output logic [3:0]  out_shade,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        MARCH,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;
    logic [5:0]    col;
    logic [4:0]    row;

    logic [15:0] org_x_r, org_y_r, org_z_r;
    logic [15:0] lin_x_r, lin_y_r, lin_z_r;
    logic [15:0] cstep_x_r, cstep_y_r, cstep_z_r;
    logic [15:0] rstep_x_r, rstep_y_r, rstep_z_r;
    logic [15:0] col_ray_x, col_ray_y, col_ray_z;
    logic [15:0] row_ray_x, row_ray_y, row_ray_z;

    logic        last_col;
    logic        last_row;
    logic        march_end;
    logic        accept;
    logic [16:0] light_sum;
    logic [16:0] light_shr;
    logic [3:0]  shade_calc;

    assign last_col  = (col == 6'(COLS - 1));
    assign last_row  = (row == 5'(ROWS - 1));
    assign march_end = (cnt == CW'(ITERS - 1));
    assign accept    = (state == OUT) && out_ready;

    // The engine sees the current column ray and the frame-latched origin/light for the whole march.
    assign eng_px  = org_x_r;
    assign eng_py  = org_y_r;
    assign eng_pz  = org_z_r;
    assign eng_rx  = col_ray_x;
    assign eng_ry  = col_ray_y;
    assign eng_rz  = col_ray_z;
    assign eng_lx  = lin_x_r;
    assign eng_ly  = lin_y_r;
    assign eng_lz  = lin_z_r;
    assign out_col = col;
    assign out_row = row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame_start restarts the grid from any state, including over a last-sample acceptance.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = START;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                START:   state_nxt = MARCH;
                MARCH:   if (march_end) state_nxt = OUT;
                OUT: begin
                    if (accept) begin
                        state_nxt = (last_col && last_row) ? IDLE : START;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        eng_start = (state == START);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // Only non-negative light contributes; the 17-bit sum leaves headroom for the dither offset.
    always_comb begin
        light_sum = {1'b0, eng_light};
`ifdef DONUT_ORDERED_DITHER_EN
        case ({row[0], col[0]})
            2'b01:   light_sum = light_sum + (17'd8 << (SHIFT - 4));
            2'b10:   light_sum = light_sum + (17'd12 << (SHIFT - 4));
            2'b11:   light_sum = light_sum + (17'd4 << (SHIFT - 4));
            default: light_sum = {1'b0, eng_light};
        endcase
`endif
        light_shr  = light_sum >> SHIFT;
        shade_calc = 4'd0;
        if (eng_hit && !eng_light[15] && (eng_light != 16'd0)) begin
            shade_calc = (light_shr > 17'd15) ? 4'd15 : light_shr[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            out_hit    <= 1'b0;
            out_shade  <= 4'd0;
            frame_done <= 1'b0;
            org_x_r    <= '0;
            org_y_r    <= '0;
            org_z_r    <= '0;
            lin_x_r    <= '0;
            lin_y_r    <= '0;
            lin_z_r    <= '0;
            cstep_x_r  <= '0;
            cstep_y_r  <= '0;
            cstep_z_r  <= '0;
            rstep_x_r  <= '0;
            rstep_y_r  <= '0;
            rstep_z_r  <= '0;
            col_ray_x  <= '0;
            col_ray_y  <= '0;
            col_ray_z  <= '0;
            row_ray_x  <= '0;
            row_ray_y  <= '0;
            row_ray_z  <= '0;
        end else begin
            frame_done <= accept && last_col && last_row && !frame_start;
            if (frame_start) begin
                org_x_r   <= org_x;
                org_y_r   <= org_y;
                org_z_r   <= org_z;
                lin_x_r   <= lin_x;
                lin_y_r   <= lin_y;
                lin_z_r   <= lin_z;
                cstep_x_r <= cstep_x;
                cstep_y_r <= cstep_y;
                cstep_z_r <= cstep_z;
                rstep_x_r <= rstep_x;
                rstep_y_r <= rstep_y;
                rstep_z_r <= rstep_z;
                col_ray_x <= ray0_x;
                col_ray_y <= ray0_y;
                col_ray_z <= ray0_z;
                row_ray_x <= ray0_x;
                row_ray_y <= ray0_y;
                row_ray_z <= ray0_z;
                col       <= '0;
                row       <= '0;
                cnt       <= '0;
            end else begin
                case (state)
                    START: cnt <= '0;
                    MARCH: begin
                        cnt <= cnt + CW'(1);
                        if (march_end) begin
                            out_hit   <= eng_hit;
                            out_shade <= shade_calc;
                        end
                    end
                    OUT: begin
                        if (accept && !(last_col && last_row)) begin
                            if (!last_col) begin
                                col       <= col + 6'd1;
                                col_ray_x <= col_ray_x + cstep_x_r;
                                col_ray_y <= col_ray_y + cstep_y_r;
                                col_ray_z <= col_ray_z + cstep_z_r;
                            end else begin
                                // Next row starts from the previous row start plus one row step.
                                col       <= '0;
                                row       <= row + 5'd1;
                                row_ray_x <= row_ray_x + rstep_x_r;
                                row_ray_y <= row_ray_y + rstep_y_r;
                                row_ray_z <= row_ray_z + rstep_z_r;
                                col_ray_x <= row_ray_x + rstep_x_r;
                                col_ray_y <= row_ray_y + rstep_y_r;
                                col_ray_z <= row_ray_z + rstep_z_r;
                            end
                        end
                    end
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_donut_ray_issuer.sv
// Testbench for donut_ray_issuer on a 3x2 grid with a stub engine whose result appears a set
// number of clocks after each start; results are checked against a scoreboard queue.
module tb_donut_ray_issuer;

    localparam int COLS  = 3;
    localparam int ROWS  = 2;
    localparam int ITERS = 8;
    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] org_x, org_y, org_z;
    logic [15:0] ray0_x, ray0_y, ray0_z;
    logic [15:0] cstep_x, cstep_y, cstep_z;
    logic [15:0] rstep_x, rstep_y, rstep_z;
    logic [15:0] lin_x, lin_y, lin_z;
    logic        eng_start;
    logic [15:0] eng_px, eng_py, eng_pz;
    logic [15:0] eng_rx, eng_ry, eng_rz;
    logic [15:0] eng_lx, eng_ly, eng_lz;
    logic        eng_hit;
    logic [15:0] eng_light;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_col;
    logic [4:0]  out_row;
    logic        out_hit;
    logic [3:0]  out_shade;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic [15:0] light;
        logic        hit;
        int          delay;
        logic        exp_hit;
        logic [3:0]  exp_shade;
    } vec_t;

    typedef struct {
        int         col;
        int         row;
        logic       hit;
        logic [3:0] shade;
    } result_t;

    vec_t        vecs[8];
    result_t     sb_q[$];
    result_t     res;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          sb_col = 0;
    int          sb_row = 0;
    int          last_start_cyc = 0;
    bit          first_start = 1'b1;
    bit          check_spacing = 1'b1;
    logic        exp_hit = 1'b0;
    logic [3:0]  exp_shade = 4'd0;
    int          stub_cnt = 0;
    int          stub_delay = 8;
    logic [15:0] stub_light = 16'd0;
    logic        stub_hit = 1'b0;

    donut_ray_issuer #(.COLS(COLS), .ROWS(ROWS), .ITERS(ITERS), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .org_x(org_x), .org_y(org_y), .org_z(org_z),
        .ray0_x(ray0_x), .ray0_y(ray0_y), .ray0_z(ray0_z),
        .cstep_x(cstep_x), .cstep_y(cstep_y), .cstep_z(cstep_z),
        .rstep_x(rstep_x), .rstep_y(rstep_y), .rstep_z(rstep_z),
        .lin_x(lin_x), .lin_y(lin_y), .lin_z(lin_z),
        .eng_start(eng_start),
        .eng_px(eng_px), .eng_py(eng_py), .eng_pz(eng_pz),
        .eng_rx(eng_rx), .eng_ry(eng_ry), .eng_rz(eng_rz),
        .eng_lx(eng_lx), .eng_ly(eng_ly), .eng_lz(eng_lz),
        .eng_hit(eng_hit), .eng_light(eng_light),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_row(out_row), .out_hit(out_hit), .out_shade(out_shade),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub engine: result becomes visible stub_delay clocks after it sees eng_start.
    always @(posedge clk) begin
        if (eng_start) stub_cnt <= 1;
        else if (stub_cnt != 0 && stub_cnt < 10000) stub_cnt <= stub_cnt + 1;
    end
    assign eng_hit   = (stub_cnt >= stub_delay) ? stub_hit : 1'b0;
    assign eng_light = (stub_cnt >= stub_delay) ? stub_light : 16'd0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Starts are checked against an independent column/row model; results are queued for the output side.
    always @(negedge clk) begin
        if (rst_n && eng_start) begin
            check_output("start_rx", 32'(eng_rx), 32'(16'(int'(ray0_x) + sb_col * int'(cstep_x) + sb_row * int'(rstep_x))));
            check_output("start_ry", 32'(eng_ry), 32'(16'(int'(ray0_y) + sb_col * int'(cstep_y) + sb_row * int'(rstep_y))));
            check_output("start_rz", 32'(eng_rz), 32'(16'(int'(ray0_z) + sb_col * int'(cstep_z) + sb_row * int'(rstep_z))));
            check_output("start_px", 32'(eng_px), 32'(org_x));
            check_output("start_lz", 32'(eng_lz), 32'(lin_z));
            check_output("start_col", 32'(out_col), 32'(sb_col));
            check_output("start_row", 32'(out_row), 32'(sb_row));
            if (!first_start && check_spacing)
                check_output("start_spacing", 32'(cyc - last_start_cyc), 32'(ITERS + 2));
            first_start    = 1'b0;
            last_start_cyc = cyc;
            sb_q.push_back('{sb_col, sb_row, exp_hit, exp_shade});
            if (sb_col == COLS - 1) begin
                sb_col = 0;
                sb_row = sb_row + 1;
            end else begin
                sb_col = sb_col + 1;
            end
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_output", 32'(1), 32'(0));
            end else begin
                res = sb_q.pop_front();
                check_output("out_col", 32'(out_col), 32'(res.col));
                check_output("out_row", 32'(out_row), 32'(res.row));
                check_output("out_hit", 32'(out_hit), 32'(res.hit));
                check_output("out_shade", 32'(out_shade), 32'(res.shade));
            end
        end
        if (rst_n && frame_done) done_count++;
    end

    task automatic apply_stimulus(input vec_t v);
        stub_light = v.light;
        stub_hit   = v.hit;
        stub_delay = v.delay;
        exp_hit    = v.exp_hit;
        exp_shade  = v.exp_shade;
    endtask

    task automatic start_frame(input bit flush);
        @(posedge clk); #1;
        frame_start = 1'b1;
        sb_col      = 0;
        sb_row      = 0;
        first_start = 1'b1;
        if (flush) sb_q.delete();
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        check_output("frame_done_seen", 32'(frame_done), 32'(1));
    endtask

    task automatic run_frame();
        int dc;
        dc = done_count;
        start_frame(1'b1);
        wait_frame_done(200);
        repeat (3) @(negedge clk);
        check_output("frame_done_once", 32'(done_count - dc), 32'(1));
        check_output("idle_after_frame", 32'(busy), 32'(0));
        check_output("queue_drained", 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        int n;
        int dc;
        vecs[0] = '{16'd300,  1'b1, 8, 1'b1, 4'd15};
        vecs[1] = '{16'd240,  1'b1, 8, 1'b1, 4'd15};
        vecs[2] = '{16'd239,  1'b1, 8, 1'b1, 4'd14};
        vecs[3] = '{16'd15,   1'b1, 8, 1'b1, 4'd0};
        vecs[4] = '{16'hFFCE, 1'b1, 8, 1'b1, 4'd0};
        vecs[5] = '{16'd200,  1'b0, 8, 1'b0, 4'd0};
        vecs[6] = '{16'd100,  1'b1, 8, 1'b1, 4'd6};
        vecs[7] = '{16'd100,  1'b1, 9, 1'b0, 4'd0};

        org_x = 16'h0100; org_y = 16'h0200; org_z = 16'hFD00;
        ray0_x = 16'd0; ray0_y = 16'd0; ray0_z = 16'd256;
        cstep_x = 16'd16; cstep_y = 16'd0; cstep_z = 16'd0;
        rstep_x = 16'd0; rstep_y = 16'd16; rstep_z = 16'd0;
        lin_x = 16'h0040; lin_y = 16'hFFC0; lin_z = 16'h0080;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 32'(0));
        check_output("reset_valid", 32'(out_valid), 32'(0));
        check_output("reset_start", 32'(eng_start), 32'(0));
        check_output("reset_done", 32'(frame_done), 32'(0));
        check_output("reset_rz", 32'(eng_rz), 32'(0));
        rst_n = 1'b1;

        // Grid walk, latency and shade boundaries: one full frame per table entry.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
            run_frame();
        end

        // Backpressure: stall the first result for 20 cycles.
        apply_stimulus(vecs[6]);
        check_spacing = 1'b0;
        out_ready = 1'b0;
        start_frame(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        for (int i = 0; i < 20; i++) begin
            check_output("stall_valid", 32'(out_valid), 32'(1));
            check_output("stall_start", 32'(eng_start), 32'(0));
            check_output("stall_col", 32'(out_col), 32'(0));
            check_output("stall_shade", 32'(out_shade), 32'(6));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("resume_start", 32'(eng_start), 32'(1));
        check_output("resume_valid", 32'(out_valid), 32'(0));
        check_output("resume_col", 32'(out_col), 32'(1));
        wait_frame_done(200);
        repeat (2) @(negedge clk);
        check_spacing = 1'b1;

        // Abort in the 4th march cycle of sample (1,0) with a new ray0.
        dc = done_count;
        start_frame(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(eng_start && out_col == 6'd1 && out_row == 5'd0) && n < 100);
        check_output("abort_sync", 32'(eng_start), 32'(1));
        repeat (4) @(posedge clk);
        #1;
        frame_start = 1'b1;
        ray0_x = 16'd100; ray0_y = 16'd0; ray0_z = 16'd0;
        sb_col = 0; sb_row = 0; first_start = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        frame_start = 1'b0;
        check_output("abort_start", 32'(eng_start), 32'(1));
        check_output("abort_rx", 32'(eng_rx), 32'(100));
        check_output("abort_col", 32'(out_col), 32'(0));
        check_output("abort_row", 32'(out_row), 32'(0));
        wait_frame_done(200);
        repeat (3) @(negedge clk);
        check_output("abort_done_count", 32'(done_count - dc), 32'(1));
        ray0_x = 16'd0; ray0_y = 16'd0; ray0_z = 16'd256;

        // Restart coincident with acceptance of the last sample suppresses frame_done.
        dc = done_count;
        start_frame(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(eng_start && out_col == 6'd2 && out_row == 5'd1) && n < 200);
        check_output("last_start_sync", 32'(eng_start), 32'(1));
        @(posedge clk); #1;
        out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        check_output("last_out_sync", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        frame_start = 1'b1;
        out_ready = 1'b1;
        sb_col = 0; sb_row = 0; first_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check_output("restart_start", 32'(eng_start), 32'(1));
        check_output("restart_col", 32'(out_col), 32'(0));
        check_output("restart_row", 32'(out_row), 32'(0));
        @(negedge clk);
        check_output("restart_no_done", 32'(frame_done), 32'(0));
        wait_frame_done(200);
        repeat (3) @(negedge clk);
        check_output("restart_done_count", 32'(done_count - dc), 32'(1));

        // Asynchronous reset while holding a result in OUT.
        out_ready = 1'b0;
        start_frame(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        check_output("reset_out_sync", 32'(out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_valid", 32'(out_valid), 32'(0));
        check_output("async_busy", 32'(busy), 32'(0));
        check_output("async_start", 32'(eng_start), 32'(0));
        check_output("async_rz", 32'(eng_rz), 32'(0));
        sb_q.delete();
        #5;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_output("post_reset_idle", 32'(busy), 32'(0));
        apply_stimulus(vecs[2]);
        run_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/donut_ray_issuer.md
Name: donut_ray_issuer

Overview:
- Initiator side of the donut hit-test engine. It walks a COLS x ROWS sample grid once per frame and incrementally generates one ray direction per sample.
- For each sample it drives the engine's start and origin/ray/light inputs, times the fixed march latency, and captures hit and light.
- It emits one shaded sample per grid point over a valid/ready handshake to the downstream line buffer.

Parameters:
- COLS, 40, samples per row (>=2)
- ROWS, 30, rows per frame (>=2)
- ITERS, 8, march clocks after start before hit/light are sampled
- SHIFT, 4, right shift applied to light to form the 4-bit shade

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- frame_start  in  1  pulse; latches frame inputs and restarts the grid at sample 0
- org_x/org_y/org_z  in  16 each  signed camera origin, 8.8 fixed point
- ray0_x/ray0_y/ray0_z  in  16 each  signed ray for sample (0,0)
- cstep_x/cstep_y/cstep_z  in  16 each  signed per-column ray increment
- rstep_x/rstep_y/rstep_z  in  16 each  signed per-row ray increment
- lin_x/lin_y/lin_z  in  16 each  signed light direction
- eng_start  out  1  start pulse to the engine
- eng_px/eng_py/eng_pz  out  16 each  origin to the engine
- eng_rx/eng_ry/eng_rz  out  16 each  ray to the engine
- eng_lx/eng_ly/eng_lz  out  16 each  light to the engine
- eng_hit  in  1  engine hit flag
- eng_light  in  16  signed engine light intensity
- out_valid  out  1  sample result valid
- out_ready  in  1  downstream accepts
- out_col  out  6  column index
- out_row  out  5  row index
- out_hit  out  1  captured hit
- out_shade  out  4  shade value
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; all internal ray, origin and light registers 0; col = row = 0.
- States: IDLE, START, MARCH, OUT.
- IDLE:
  - On frame_start, latch org, ray0, cstep, rstep and lin.
  - Set col_ray = row_ray = ray0, col = row = 0.
  - Go to START.
- START (1 cycle):
  - eng_start = 1.
  - eng_r* = col_ray; eng_p* and eng_l* = latched values.
  - Go to MARCH and clear the counter to 0.
- MARCH:
  - eng_start = 0. eng_* hold their values throughout.
  - Counter increments each cycle.
  - On the cycle the counter equals ITERS-1: capture eng_hit and eng_light at that clock edge (ITERS+1 edges after the START edge), then go to OUT.
- Shade computation:
  - If hit = 0 or light <= 0: shade = 0.
  - Otherwise: shade = min(light >>> SHIFT, 15). With default SHIFT = 4, light >= 240 gives 15.
- OUT:
  - out_valid = 1. out_col, out_row, out_hit and out_shade are stable until acceptance.
  - Acceptance = out_valid & out_ready. On acceptance, out_valid drops the next cycle.
  - If not last in row: col++, col_ray += cstep, go to START.
  - If last in row but not last row: col = 0, row++, row_ray += rstep, col_ray = row_ray + rstep, go to START.
  - If last sample: frame_done pulses 1 cycle, go to IDLE.
  - out_ready low stalls indefinitely in OUT; no new start is issued.
- Ray arithmetic: 16-bit two's-complement wrap, no saturation.
- Throughput: ITERS+2 cycles per sample with out_ready held high (START + ITERS MARCH + 1 OUT).
- frame_start in any non-IDLE state:
  - Abort the current sample; out_valid = 0 on the next cycle.
  - Relatch all frame inputs and restart at sample (0,0) in START.
  - No frame_done is emitted for the aborted frame.
- frame_start coincident with acceptance of the last sample: the restart wins; frame_done is not pulsed.
- Async reset during MARCH or OUT: immediate return to reset values; the engine may finish its march, and its result is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: DONUT_ORDERED_DITHER_EN.
- Defined: before the shift, add a 2x2 Bayer offset to positive light.
  - Offsets are {0,8,12,4} << (SHIFT-4), indexed by {row[0],col[0]} = 00,01,10,11 respectively.
  - The sum is computed 17 bits wide, then shifted and saturated to 15.
- Undefined: no offset, behaviour exactly as above.
- Miss or non-positive light gives 0 in both cases.

Test Plan:
- Grid walk:
  - Setup: COLS = 3, ROWS = 2, ray0 = (0,0,256), cstep = (16,0,0), rstep = (0,16,0), out_ready = 1.
  - Expected eng_rx per start: 0, 16, 32, 0, 16, 32. Expected eng_ry: 0, 0, 0, 16, 16, 16.
  - 6 results; frame_done pulses once after the 6th; starts are spaced exactly 10 cycles apart.
- Latency:
  - Setup: a stub engine drives eng_light = 100, eng_hit = 1 only from 8 clocks after start.
  - Expected: out_shade = 6 and out_hit = 1. A stub that drives values 1 cycle late yields shade 0, confirming the sample point.
- Shade boundaries (light, hit -> shade): (300,1) -> 15; (240,1) -> 15; (239,1) -> 14; (15,1) -> 0; (-50,1) -> 0; (200,0) -> 0 with out_hit = 0.
- Backpressure:
  - Stimulus: out_ready held low for 20 cycles in OUT.
  - Expected: outputs stable, eng_start stays low, no index advance; acceptance on the ready cycle, then START on the next cycle.
- Abort:
  - Stimulus: frame_start in the 4th MARCH cycle of sample (1,0) with new ray0 = (100,0,0).
  - Expected: the next eng_start carries eng_rx = 100 with out_col = 0, out_row = 0; no frame_done for the aborted frame.
- Reset:
  - Stimulus: rst_n low asynchronously in OUT.
  - Expected: out_valid, busy and eng_start drop with no clock edge; the grid restarts only on the next frame_start.
